// File: rtl/display_scan_controller.sv
// Scan controller for 3 active digits of a 4-digit seven-segment display, with
// shadow-buffered data commit at frame start. Define SCAN_BLANK_EN for per-slot anti-ghost blanking.
module display_scan_controller #(
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [3:0] opCodeIn,
  input  logic [7:0] resultIn,
  output logic [3:0] opCode,
  output logic [3:0] lowerBits,
  output logic [3:0] upperBits,
  output logic [3:0] anode,
  output logic       pending,
  output logic       frameStart
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  if (CLK_DIV < 2 || BLANK_CYCLES >= CLK_DIV) begin : g_param_check
    $error("display_scan_controller: need CLK_DIV >= 2 and BLANK_CYCLES < CLK_DIV");
  end

  typedef enum logic [1:0] {IDLE, DIG_OP, DIG_LO, DIG_HI} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             tick;
  logic             enter_op;
  logic [3:0]       anode_next;
  logic [3:0]       shadow_op;
  logic [7:0]       shadow_res;

  always_comb begin
    tick       = enable && (count == CNT_W'(CLK_DIV - 1));
    count_next = count + CNT_W'(1);
    if (!enable || tick) count_next = '0;

    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else if (tick) begin
      case (state)
        IDLE:    state_next = DIG_OP;
        DIG_OP:  state_next = DIG_LO;
        DIG_LO:  state_next = DIG_HI;
        DIG_HI:  state_next = DIG_OP;
        default: state_next = IDLE;
      endcase
    end

    enter_op = (state_next == DIG_OP) && (state != DIG_OP);

    case (state_next)
      DIG_OP:  anode_next = 4'b1110;
      DIG_LO:  anode_next = 4'b1011;
      DIG_HI:  anode_next = 4'b0111;
      default: anode_next = 4'b1111;
    endcase
`ifdef SCAN_BLANK_EN
    // Prescaler restarts at every slot entry, so it doubles as the in-slot cycle index.
    if (count_next < CNT_W'(BLANK_CYCLES)) anode_next = 4'b1111;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      anode      <= 4'b1111;
      frameStart <= 1'b0;
      pending    <= 1'b0;
      opCode     <= '0;
      lowerBits  <= '0;
      upperBits  <= '0;
      shadow_op  <= '0;
      shadow_res <= '0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      anode      <= anode_next;
      frameStart <= enter_op;
      // A load on the commit edge bypasses the shadow so the newest value wins.
      if (enter_op && load) begin
        opCode    <= opCodeIn;
        lowerBits <= resultIn[3:0];
        upperBits <= resultIn[7:4];
        pending   <= 1'b0;
      end else if (enter_op && pending) begin
        opCode    <= shadow_op;
        lowerBits <= shadow_res[3:0];
        upperBits <= shadow_res[7:4];
        pending   <= 1'b0;
      end else if (load) begin
        shadow_op  <= opCodeIn;
        shadow_res <= resultIn;
        pending    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller (CLK_DIV=4, BLANK_CYCLES=1);
// committed data is tracked through a scoreboard queue filled at load time.
module tb_display_scan_controller;

  localparam int unsigned DIV   = 4;
  localparam int unsigned BLANK = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load;
  logic [3:0] opCodeIn;
  logic [7:0] resultIn;
  logic [3:0] opCode;
  logic [3:0] lowerBits;
  logic [3:0] upperBits;
  logic [3:0] anode;
  logic       pending;
  logic       frameStart;

  int passed = 0;
  int total  = 0;

  logic [11:0] sb[$];
  logic [11:0] exp_data;
  logic        exp_pend;

  display_scan_controller #(.CLK_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .opCodeIn(opCodeIn), .resultIn(resultIn),
    .opCode(opCode), .lowerBits(lowerBits), .upperBits(upperBits),
    .anode(anode), .pending(pending), .frameStart(frameStart)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  // Sample index t counts clock edges since scanning began (t=0: before first edge).
  function automatic logic [3:0] exp_anode(int t);
    int s = t / int'(DIV);
    int p = t % int'(DIV);
    logic [3:0] a;
    if (s == 0) a = 4'b1111;
    else begin
      case ((s - 1) % 3)
        0:       a = 4'b1110;
        1:       a = 4'b1011;
        default: a = 4'b0111;
      endcase
    end
`ifdef SCAN_BLANK_EN
    if (s != 0 && p < int'(BLANK)) a = 4'b1111;
`else
    if (p < 0) a = 4'bxxxx;
`endif
    return a;
  endfunction

  function automatic logic exp_fs(int t);
    int s = t / int'(DIV);
    return (s >= 1) && (((s - 1) % 3) == 0) && ((t % int'(DIV)) == 0);
  endfunction

  task automatic do_reset(input logic en);
    reset = 1'b1; enable = en; load = 1'b0; opCodeIn = '0; resultIn = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_data = '0;
    exp_pend = 1'b0;
  endtask

  task automatic drive_load(input logic [3:0] op, input logic [7:0] res);
    load = 1'b1; opCodeIn = op; resultIn = res;
    if (sb.size() > 0) sb[sb.size() - 1] = {op, res};
    else sb.push_back({op, res});
    exp_pend = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; load = 1'b0; opCodeIn = 4'hF; resultIn = 8'hFF;
    repeat (2) @(negedge clk);
    total++;
    if (anode !== 4'b1111) $display("FAIL reset_anode got %b want 1111", anode);
    else passed++;
    total++;
    if ({opCode, upperBits, lowerBits} !== 12'h000)
      $display("FAIL reset_data got %h want 000", {opCode, upperBits, lowerBits});
    else passed++;
    total++;
    if (pending !== 1'b0) $display("FAIL reset_pending got %b want 0", pending);
    else passed++;
    total++;
    if (frameStart !== 1'b0) $display("FAIL reset_framestart got %b want 0", frameStart);
    else passed++;
  endtask

  task automatic test_scan;
    do_reset(1'b1);
    for (int k = 0; k < 28; k++) begin
      total++;
      if (anode !== exp_anode(k)) $display("FAIL scan_anode k=%0d got %b want %b", k, anode, exp_anode(k));
      else passed++;
      total++;
      if (frameStart !== exp_fs(k)) $display("FAIL scan_framestart k=%0d got %b want %b", k, frameStart, exp_fs(k));
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_load;
    do_reset(1'b1);
    for (int k = 0; k < 24; k++) begin
      if (exp_fs(k) && sb.size() > 0) begin exp_data = sb.pop_front(); exp_pend = 1'b0; end
      total++;
      if (anode !== exp_anode(k)) $display("FAIL load_anode k=%0d got %b want %b", k, anode, exp_anode(k));
      else passed++;
      total++;
      if ({opCode, upperBits, lowerBits} !== exp_data)
        $display("FAIL load_data k=%0d got %h want %h", k, {opCode, upperBits, lowerBits}, exp_data);
      else passed++;
      total++;
      if (pending !== exp_pend) $display("FAIL load_pending k=%0d got %b want %b", k, pending, exp_pend);
      else passed++;
      load = 1'b0;
      if (k == 8) drive_load(4'hA, 8'h3C);
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    do_reset(1'b1);
    for (int k = 0; k < 33; k++) begin
      if (exp_fs(k) && sb.size() > 0) begin exp_data = sb.pop_front(); exp_pend = 1'b0; end
      total++;
      if (frameStart !== exp_fs(k)) $display("FAIL b2b_framestart k=%0d got %b want %b", k, frameStart, exp_fs(k));
      else passed++;
      total++;
      if ({opCode, upperBits, lowerBits} !== exp_data)
        $display("FAIL b2b_data k=%0d got %h want %h", k, {opCode, upperBits, lowerBits}, exp_data);
      else passed++;
      total++;
      if (pending !== exp_pend) $display("FAIL b2b_pending k=%0d got %b want %b", k, pending, exp_pend);
      else passed++;
      load = 1'b0;
      if (k == 5)  drive_load(4'h1, 8'h11);
      if (k == 9)  drive_load(4'h2, 8'h22);
      if (k == 27) drive_load(4'h5, 8'h96);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (anode !== 4'b1111) $display("FAIL midreset_anode got %b want 1111", anode);
    else passed++;
    total++;
    if ({opCode, upperBits, lowerBits} !== 12'h000)
      $display("FAIL midreset_data got %h want 000", {opCode, upperBits, lowerBits});
    else passed++;
    total++;
    if (pending !== 1'b0) $display("FAIL midreset_pending got %b want 0", pending);
    else passed++;
  endtask

  task automatic test_enable_toggle;
    logic [3:0] ea;
    logic       ef;
    do_reset(1'b1);
    for (int k = 0; k < 31; k++) begin
      if (k >= 14 && k < 19) begin ea = 4'b1111; ef = 1'b0; end
      else begin
        ea = exp_anode(k < 19 ? k : k - 19);
        ef = exp_fs(k < 19 ? k : k - 19);
      end
      if (ef && sb.size() > 0) begin exp_data = sb.pop_front(); exp_pend = 1'b0; end
      total++;
      if (anode !== ea) $display("FAIL en_anode k=%0d got %b want %b", k, anode, ea);
      else passed++;
      total++;
      if (frameStart !== ef) $display("FAIL en_framestart k=%0d got %b want %b", k, frameStart, ef);
      else passed++;
      total++;
      if ({opCode, upperBits, lowerBits} !== exp_data)
        $display("FAIL en_data k=%0d got %h want %h", k, {opCode, upperBits, lowerBits}, exp_data);
      else passed++;
      total++;
      if (pending !== exp_pend) $display("FAIL en_pending k=%0d got %b want %b", k, pending, exp_pend);
      else passed++;
      load = 1'b0;
      if (k == 0)  drive_load(4'h7, 8'h5E);
      if (k == 13) enable = 1'b0;
      if (k == 15) drive_load(4'h4, 8'hC1);
      if (k == 19) enable = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_load;
    test_back_to_back;
    test_enable_toggle;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
